boot_loader: RTL
================

# boot_loader

Boot loader and memory-port owner for the 8-bit multicycle MIPS core. While loading, it holds the core in reset and owns the single memory port, writing a checksummed byte stream from a host into program memory. After a good load it releases the core and passes the core's memory bus straight through. A host `boot_req` halts the core and re-enters load mode.

## Interface
Parameters:
- `WIDTH`, 8: data and address width; matches the core.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `boot_req` in 1: one-cycle pulse; abort or halt and return to load mode.
- `ld_valid` in 1: host byte valid.
- `ld_data` in WIDTH: host byte.
- `ld_ready` out 1: loader can accept a byte.
- `core_memread` in 1: core memory read request.
- `core_memwrite` in 1: core memory write request.
- `core_adr` in WIDTH: core memory address.
- `core_writedata` in WIDTH: core write data.
- `core_rst` out 1: active-high reset to the core.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_adr` out WIDTH: memory address.
- `mem_wdata` out WIDTH: memory write data.
- `running` out 1: core released (state RUN).
- `err` out 1: last load failed its checksum (sticky).

## Operation
- Frame format: `ADDR` byte, `LEN` byte, `LEN` data bytes, `CSUM` byte.
  - `LEN`=0 means 2^WIDTH bytes. Length counter is WIDTH+1 bits.
- A byte is accepted on any cycle with `ld_valid && ld_ready`.
- States and transitions:
  - IDLE: accepting an `ADDR` byte loads the address pointer, clears the checksum accumulator and clears `err`; go to LEN.
  - LEN: on accept, load the remaining-byte count; go to DATA.
  - DATA: on each accept, register a write of the byte to the pointer address. Pointer increments mod 2^WIDTH (wraps 0xFF→0x00). Accumulator adds the byte mod 2^WIDTH. Count decrements; after the last byte, go to CSUM.
  - CSUM: on accept, if the byte equals the accumulator go to RUN. Otherwise set `err` and go to IDLE.
  - RUN: `ld_ready`=0; stream bytes are ignored.
- `boot_req` in any state goes to IDLE next edge. In a load state it aborts the frame with no further writes and `err` unchanged.
- Memory port mux:
  - In RUN, `mem_*` are combinational pass-through of `core_*`.
  - In all other states, `mem_read`=0 and `mem_write`/`mem_adr`/`mem_wdata` come from the loader write register.
- `core_rst` is registered: 1 in every state except RUN.

## Timing
- Reset (`rst` low) values:
  - state=IDLE, `core_rst`=1, `ld_ready`=0, `mem_write`=0, `mem_read`=0, `mem_adr`=0, `mem_wdata`=0, `running`=0, `err`=0.
- `ld_ready` is registered: 1 from the first edge after `rst` rises, in every state except RUN.
- Loader write latency: a byte accepted at edge k drives `mem_write`=1 with its address and data for exactly the cycle after edge k. Back-to-back accepts give back-to-back writes; there is no backpressure.
- The final data write has always completed before CSUM can be accepted, so no write is pending when entering RUN.
- RUN entry: for a CSUM accept at edge k, state=RUN, `core_rst`=0 and `running`=1 after edge k. The core's first fetch occurs in the cycle after edge k.
- `boot_req` at edge k in RUN: after edge k, `core_rst`=1 and `mem_*` are driven by the loader (idle). A core access in the cycle that ends at edge k still passes through.
- Simultaneous `boot_req` and an accepted byte: `boot_req` wins; the byte is dropped and no write is issued.
- Reset mid-frame: the frame is discarded, and the write register clears asynchronously.

## Structure
- The shared package `mips_pkg` holds the `boot_state_t` enum (IDLE, LEN, DATA, CSUM, RUN) and the byte-width localparams.
- The block is a single flat module with no sub-modules. The mux, FSM, counter and accumulator are small.

## Test plan
- Reset, then frame 0x10, 0x03, 0xAA, 0xBB, 0xCC, 0x31 → writes 0x10=AA, 0x11=BB, 0x12=CC on consecutive cycles. `core_rst` falls the cycle after CSUM is accepted, and `running`=1.
- Same frame with CSUM 0x32 → `err`=1, state IDLE, `core_rst` stays 1. A following good frame clears `err` when its ADDR is accepted.
- Frame ADDR 0xFE, LEN 0x03 → writes go to 0xFE, 0xFF, 0x00 (wrap). LEN 0x00 → exactly 256 writes before CSUM.
- In RUN, drive `core_memwrite`=1, `core_adr`=0x40, `core_writedata`=0x5A → same values on `mem_*` in the same cycle. `ld_valid` is ignored and `ld_ready`=0.
- `boot_req` pulse in RUN → `core_rst`=1 next cycle and `mem_write`=0. `boot_req` mid-DATA after 1 of 3 bytes → only 1 write, state IDLE.
- Assert `rst` low mid-DATA with a write pending → `mem_write`=0 immediately, `ld_ready`=0, and `ld_ready`=1 one edge after release.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and widths for the 8-bit multicycle MIPS system
package mips_pkg;

  localparam int BYTE_W = 8;

  // Boot loader states: frame parse (IDLE..CSUM) and core released (RUN)
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4
  } boot_state_t;

endpackage

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - host frame loader and memory-port owner for the MIPS core
module boot_loader
  import mips_pkg::*;
#(
  parameter int WIDTH = BYTE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_req,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic             core_memread,
  input  logic             core_memwrite,
  input  logic [WIDTH-1:0] core_adr,
  input  logic [WIDTH-1:0] core_writedata,
  output logic             core_rst,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             running,
  output logic             err
);

  boot_state_t      state_q, state_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH:0]   cnt_q, cnt_d;      // one extra bit so LEN=0 can mean 2^WIDTH
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             err_q, err_d;
  logic             ld_ready_q;
  logic             core_rst_q;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] wr_adr_q, wr_adr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             accept;

  assign accept = ld_valid && ld_ready_q;

  // Frame parser: boot_req overrides any accepted byte, so an abort never writes
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    err_d     = err_q;
    wr_d      = 1'b0;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    if (boot_req) begin
      state_d = IDLE;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          ptr_d   = ld_data;
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = LEN;
        end
        LEN: begin
          cnt_d   = (ld_data == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, ld_data};
          state_d = DATA;
        end
        DATA: begin
          wr_d      = 1'b1;
          wr_adr_d  = ptr_q;
          wr_data_d = ld_data;
          ptr_d     = ptr_q + WIDTH'(1);
          acc_d     = acc_q + ld_data;
          cnt_d     = cnt_q - (WIDTH+1)'(1);
          if (cnt_q == (WIDTH+1)'(1)) state_d = CSUM;
        end
        CSUM: begin
          if (ld_data == acc_q) begin
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, datapath and the registered loader write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      ld_ready_q <= 1'b0;
      core_rst_q <= 1'b1;
      wr_q       <= 1'b0;
      wr_adr_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      ld_ready_q <= (state_d != RUN);
      core_rst_q <= (state_d != RUN);
      wr_q       <= wr_d;
      wr_adr_q   <= wr_adr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Memory port owner: core passes straight through only while running
  always_comb begin
    mem_read  = 1'b0;
    mem_write = wr_q;
    mem_adr   = wr_adr_q;
    mem_wdata = wr_data_q;
    if (state_q == RUN) begin
      mem_read  = core_memread;
      mem_write = core_memwrite;
      mem_adr   = core_adr;
      mem_wdata = core_writedata;
    end
  end

  assign ld_ready = ld_ready_q;
  assign core_rst = core_rst_q;
  assign running  = (state_q == RUN);
  assign err      = err_q;

endmodule
